// File: rtl/uart_reg_cmd_initiator.sv
// uart_reg_cmd_initiator: UART register-access master; sends a read/write command
// frame (8N1) and checks the response frame, reporting data or error on rsp_valid.
module uart_reg_cmd_initiator #(
    parameter int CLKS_PER_BIT   = 217,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        uart_tx,
    input  logic        uart_rx
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;
    state_t state, state_nx;

    logic [47:0]   cmd;
    logic [9:0]    tx_sr;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [2:0]    tx_left;
    logic          wr_q;
    logic          rx_s1, rx_s2, rx_s3, rx_active;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_data;
    logic [23:0]   to_cnt;
    logic [1:0]    rsp_cnt;
    logic [23:0]   rd_sh;
    logic          accept, bit_end, send_done, rx_tick, byte_done, fin, fin_err, fin_load;

    assign req_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign rsp_valid = state == DONE;
    assign uart_tx   = tx_sr[0];
    assign accept    = req_valid && req_ready;
    assign bit_end   = tx_cnt == CW'(CLKS_PER_BIT - 1);
    assign send_done = state == SEND && bit_end && tx_bit == 4'd9 && tx_left == 3'd1;
    // first tick lands mid start bit, later ticks at each bit centre
    assign rx_tick   = rx_active && rx_cnt == (rx_bit == 4'd0 ? CW'(CLKS_PER_BIT / 2 - 1) : CW'(CLKS_PER_BIT - 1));
    assign byte_done = rx_tick && rx_bit == 4'd9;

    always_ff @(posedge core_clk) begin
        if (core_rst) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_load = 1'b0;
        case (state)
            IDLE: state_nx = accept ? SEND : IDLE;
            SEND: state_nx = send_done ? WAIT_RSP : SEND;
            WAIT_RSP: begin
                if (byte_done) begin
                    if (!rx_s2) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else if (wr_q) begin
                        fin     = 1'b1;
                        fin_err = rx_data != 8'h4B;
                    end else if (rsp_cnt == 2'd3) begin
                        fin      = 1'b1;
                        fin_load = 1'b1;
                    end
                end else if (to_cnt == 24'(TIMEOUT_CYCLES - 1)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
                state_nx = fin ? DONE : WAIT_RSP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            cmd       <= '0;
            tx_sr     <= '1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_left   <= '0;
            wr_q      <= 1'b0;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_s3     <= 1'b1;
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_data   <= '0;
            to_cnt    <= '0;
            rsp_cnt   <= '0;
            rd_sh     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            if (accept) begin
                wr_q    <= req_wr;
                cmd     <= {req_addr, req_wdata, 8'h00};
                tx_sr   <= {1'b1, req_wr ? 8'h57 : 8'h52, 1'b0};
                tx_cnt  <= '0;
                tx_bit  <= '0;
                tx_left <= req_wr ? 3'd6 : 3'd2;
            end else if (state == SEND) begin
                tx_cnt <= bit_end ? '0 : tx_cnt + 1'b1;
                if (bit_end && tx_bit == 4'd9) begin
                    tx_bit  <= '0;
                    tx_left <= tx_left - 3'd1;
                    if (tx_left != 3'd1) begin
                        tx_sr <= {1'b1, cmd[47:40], 1'b0};
                        cmd   <= {cmd[39:0], 8'h00};
                    end
                end else if (bit_end) begin
                    tx_bit <= tx_bit + 4'd1;
                    tx_sr  <= {1'b1, tx_sr[9:1]};
                end
            end
            if (!rx_active) begin
                if (rx_s3 && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= '0;
                    rx_bit    <= '0;
                end
            end else if (rx_tick) begin
                rx_cnt <= '0;
                rx_bit <= rx_bit + 4'd1;
                if ((rx_bit == 4'd0 && rx_s2) || rx_bit == 4'd9) rx_active <= 1'b0;
                else if (rx_bit != 4'd0) rx_data <= {rx_s2, rx_data[7:1]};
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            to_cnt  <= (state != WAIT_RSP || byte_done) ? '0 : to_cnt + 24'd1;
            rsp_cnt <= state != WAIT_RSP ? 2'd0 : byte_done ? rsp_cnt + 2'd1 : rsp_cnt;
            if (state == WAIT_RSP && byte_done) rd_sh <= {rd_sh[15:0], rx_data};
            if (fin) rsp_err <= fin_err;
            if (fin_load) rsp_rdata <= {rd_sh, rx_data};
        end
    end
endmodule
